// File: rtl/config_chain_pkg.sv
// Shared types and helpers for the serial configuration chain loader.
package config_chain_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRead,
    StFin
  } state_e;

  localparam logic ModeLoad = 1'b0;
  localparam logic ModeRead = 1'b1;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/config_chain_loader.sv
// Host-side driver for the tile configuration chain: serial load of parallel words and
// non-destructive rotating readback packed back into words.
module config_chain_loader
  import config_chain_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              config_en,
  output logic              config_in,
  input  logic              config_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWORDS   = ceil_div(CHAIN_LEN, WORD_W);
  localparam int unsigned LastBits = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int unsigned BitW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordW    = $clog2(NWORDS + 1);
  localparam int unsigned BufW     = $clog2(WORD_W + 1);

  localparam logic [BitW-1:0]  BitLast  = BitW'(CHAIN_LEN - 1);
  localparam logic [BitW-1:0]  BitTerm  = BitW'(CHAIN_LEN);
  localparam logic [WordW-1:0] WordTerm = WordW'(NWORDS);
  localparam logic [WordW-1:0] WordLast = WordW'(NWORDS - 1);
  localparam logic [BufW-1:0]  BufFull  = BufW'(WORD_W);
  localparam logic [BufW-1:0]  BufTail  = BufW'(LastBits);
  localparam logic [BufW-1:0]  PackTop  = BufW'(WORD_W - 1);

  state_e            state;
  logic [BitW-1:0]   bit_cnt;
  logic [WordW-1:0]  word_cnt;
  logic [WORD_W-1:0] buf_data;
  logic [BufW-1:0]   buf_cnt;
  logic [WORD_W-1:0] pack_data;
  logic [BufW-1:0]   pack_cnt;

  logic              load_en;
  logic              read_en;
  logic              accept;
  logic              pack_done;
  logic [WORD_W-1:0] pack_word;

  assign busy      = (state != StIdle);
  assign load_en   = (state == StLoad) && (buf_cnt != '0);
  // Ready while the buffer is empty or draining its final bit, so back-to-back words never bubble.
  assign cfg_ready = (state == StLoad) && (buf_cnt <= BufW'(1)) && (word_cnt < WordTerm);
  assign accept    = cfg_valid && cfg_ready;
  assign read_en   = (state == StRead) && (!rd_valid || rd_ready) && (bit_cnt != BitTerm);
  assign config_en = load_en || read_en;
  assign config_in = (state == StLoad) ? buf_data[0] :
                     (state == StRead) ? config_out  : 1'b0;

  assign pack_word = pack_data | (WORD_W'(config_out) << pack_cnt);
  assign pack_done = read_en && ((pack_cnt == PackTop) || (bit_cnt == BitLast));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      buf_data  <= '0;
      buf_cnt   <= '0;
      pack_data <= '0;
      pack_cnt  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            buf_cnt   <= '0;
            pack_data <= '0;
            pack_cnt  <= '0;
            rd_valid  <= 1'b0;
            unique case (mode)
              ModeLoad: state <= StLoad;
              ModeRead: state <= StRead;
            endcase
          end
        end

        StLoad: begin
          if (accept) begin
            buf_data <= cfg_data;
            buf_cnt  <= (word_cnt == WordLast) ? BufTail : BufFull;
            word_cnt <= word_cnt + 1'b1;
          end else if (load_en) begin
            buf_data <= buf_data >> 1;
            buf_cnt  <= buf_cnt - 1'b1;
          end
          if (load_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BitLast) begin
              state <= StFin;
              done  <= 1'b1;
            end
          end
        end

        StRead: begin
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
          end
          if (read_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (pack_done) begin
              rd_data   <= pack_word;
              rd_valid  <= 1'b1;
              pack_data <= '0;
              pack_cnt  <= '0;
              word_cnt  <= word_cnt + 1'b1;
            end else begin
              pack_data <= pack_word;
              pack_cnt  <= pack_cnt + 1'b1;
            end
          end
          // All bits rotated; leave once the final word has been taken.
          if ((bit_cnt == BitTerm) && rd_valid && rd_ready) begin
            state <= StFin;
            done  <= 1'b1;
          end
        end

        StFin: begin
          state <= StIdle;
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized self-checking bench for config_chain_loader against a 40-bit chain model.
module tb_config_chain_loader;

  localparam int unsigned ChainLen = 40;
  localparam int unsigned WordW    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic              cfg_valid;
  logic [WordW-1:0]  cfg_data;
  logic              cfg_ready;
  logic              rd_valid;
  logic [WordW-1:0]  rd_data;
  logic              rd_ready;
  logic              config_en;
  logic              config_in;
  logic              config_out;
  logic              busy;
  logic              done;

  config_chain_loader #(
    .CHAIN_LEN(ChainLen),
    .WORD_W   (WordW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .config_en (config_en),
    .config_in (config_in),
    .config_out(config_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Chain model: bits enter at the head (bit 39) and leave from the tail (bit 0).
  logic [ChainLen-1:0] chain = '0;
  always @(posedge clk) begin
    if (config_en) chain <= {config_in, chain[ChainLen-1:1]};
  end
  assign config_out = chain[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit               exp_bits[$];
  logic [WordW-1:0] exp_words[$];
  logic [WordW-1:0] got_words[$];
  bit               in_read = 1'b0;

  int               en_cnt = 0;
  int               done_cnt = 0;
  int               last_en_cyc = 0;
  int               done_cyc = 0;
  logic             hs_pending = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WordW-1:0] prev_rd = '0;

  // Per-cycle compare against the model queues, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (hs_pending) check("hs_to_en", config_en, 1);
      hs_pending <= cfg_valid && cfg_ready;
      if (config_en) begin
        en_cnt      <= en_cnt + 1;
        last_en_cyc <= cyc;
        if (!in_read) begin
          check("bit_expected", exp_bits.size() != 0, 1);
          if (exp_bits.size() != 0) check("load_bit", config_in, exp_bits.pop_front());
        end else begin
          check("rotate", config_in, config_out);
        end
      end
      if (in_read) begin
        if (rd_valid && rd_ready) begin
          check("word_expected", exp_words.size() != 0, 1);
          if (exp_words.size() != 0) check("rd_word", rd_data, exp_words.pop_front());
          got_words.push_back(rd_data);
        end
        if (rd_valid && !rd_ready) check("stall_en", config_en, 0);
        if (prev_stall) check("rd_hold", rd_data, prev_rd);
      end
      prev_stall <= in_read && rd_valid && !rd_ready;
      prev_rd    <= rd_data;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cfg_ready_seen", ok, 1);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1);
  endtask

  task automatic run_load(input logic [WordW-1:0] w0, w1, w2, input int g1, g2, input bit poke);
    logic [WordW-1:0] w[3];
    int gaps[3];
    int s_cyc, en0, dn0;
    bit ok;
    w[0] = w0; w[1] = w1; w[2] = w2;
    gaps[0] = 0; gaps[1] = g1; gaps[2] = g2;
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < ((j == 2) ? 8 : 16); b++) exp_bits.push_back(w[j][b]);
    in_read = 1'b0;
    en0 = en_cnt;
    dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (gaps[j] > 0) begin
        wait_ready(ok);
        repeat (gaps[j]) @(posedge clk);
        #1;
      end
      cfg_valid = 1'b1;
      cfg_data  = w[j];
      wait_ready(ok);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      cfg_data  = WordW'($urandom);
      if (poke && j == 0) begin
        start = 1'b1; mode = 1'b1;
      end
      if (poke && j == 1) start = 1'b0;
    end
    wait_done(200, ok);
    @(negedge clk);
    check("load_busy_after", busy, 0);
    check("load_en_count", en_cnt - en0, 40);
    check("bits_consumed", exp_bits.size(), 0);
    check("load_span", last_en_cyc - s_cyc, 41 + g1 + g2);
    check("done_after_last_en", done_cyc - last_en_cyc, 1);
    check("load_done_pulses", done_cnt - dn0, 1);
    exp_bits.delete();
  endtask

  task automatic run_read(input int stall, input bit rnd);
    logic [ChainLen-1:0] snap;
    logic [WordW-1:0] wj;
    int en0, dn0, stall_cnt;
    bit seen;
    snap = chain;
    exp_words.delete();
    got_words.delete();
    for (int j = 0; j < 3; j++) begin
      wj = snap[16*j +: 16];
      if (j == 2) wj = {8'h00, wj[7:0]};
      exp_words.push_back(wj);
    end
    in_read = 1'b1;
    en0 = en_cnt;
    dn0 = done_cnt;
    rd_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stall_cnt = 0;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (rd_valid && stall_cnt < stall) stall_cnt++;
      @(posedge clk); #1;
      rd_ready = (stall_cnt >= stall) && (!rnd || $urandom_range(0, 3) != 0);
    end
    rd_ready = 1'b0;
    check("read_done_seen", seen, 1);
    @(negedge clk);
    check("read_busy_after", busy, 0);
    check("words_left", exp_words.size(), 0);
    check("words_got", got_words.size(), 3);
    check("chain_restored", chain, snap);
    check("read_en_count", en_cnt - en0, 40);
    check("read_done_pulses", done_cnt - dn0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [WordW-1:0] r0, r1, r2;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0; rd_ready = 1'b0;
    #2;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_config_en", config_en, 0);
    check("rst_config_in", config_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Continuous load, then plain readback.
    run_load(16'hA5C3, 16'h1234, 16'h00FF, 0, 0, 1'b0);
    check("chain_after_load", chain, 40'hFF_1234_A5C3);
    run_read(0, 1'b0);
    check("t2_word0", got_words[0], 16'hA5C3);
    check("t2_word1", got_words[1], 16'h1234);
    check("t2_word2", got_words[2], 16'h00FF);

    // Gapped load, then readback with the first word stalled.
    run_load(16'hA5C3, 16'h1234, 16'h00FF, 5, 5, 1'b0);
    run_read(0, 1'b0);
    run_read(7, 1'b0);
    check("t4_word0", got_words[0], 16'hA5C3);
    check("t4_word2", got_words[2], 16'h00FF);

    // Upper bits of the last word never reach the chain.
    run_load(16'hA5C3, 16'h1234, 16'hABFF, 0, 0, 1'b0);
    check("t5_chain", chain, 40'hFF_1234_A5C3);
    run_read(0, 1'b0);
    check("t5_word2", got_words[2], 16'h00FF);

    // start during LOAD must be ignored.
    run_load(16'h0F0F, 16'hBEEF, 16'h0081, 0, 0, 1'b1);
    check("poke_chain", chain, 40'h81_BEEF_0F0F);

    // Abort a load with an asynchronous reset mid-cycle.
    in_read = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_valid = 1'b1; cfg_data = 16'hFFFF;
    for (int b = 0; b < 16; b++) exp_bits.push_back(1'b1);
    wait_ready(ok);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_cfg_ready", cfg_ready, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_data", rd_data, 0);
    check("abort_config_en", config_en, 0);
    check("abort_config_in", config_in, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_bits.delete();
    @(posedge clk); #1 reset = 1'b1;
    run_load(16'h1357, 16'h2468, 16'h00C5, 0, 0, 1'b0);
    run_read(0, 1'b0);
    check("fresh_word0", got_words[0], 16'h1357);

    // Randomized words, gaps and consumer back-pressure.
    for (int it = 0; it < 6; it++) begin
      r0 = WordW'($urandom);
      r1 = WordW'($urandom);
      r2 = WordW'($urandom);
      run_load(r0, r1, r2, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
      check("rand_chain", chain, {r2[7:0], r1, r0});
      run_read($urandom_range(0, 3), 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Host-side driver for the serial configuration chain (config_en / config_in / config_out) of the MLBlock tiles.
- Load mode: accepts parallel configuration words over a valid/ready stream and shifts them into the chain at one bit per clock.
- Readback mode: rotates the chain non-destructively (config_in fed from config_out) and packs the bits back into words.
- Sits between the configuration controller / host bus and the first tile's config_in; the last tile's config_out returns here.

Parameters:
- CHAIN_LEN, 256: total bits in the attached chain.
- WORD_W, 32: width of the load and readback words.
- NWORDS (localparam), ceil(CHAIN_LEN/WORD_W): words per full load or readback.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin an operation; sampled only in IDLE
- mode  input  1  0 = load, 1 = readback; sampled with start
- cfg_valid  input  1  load word valid
- cfg_data  input  WORD_W  load word
- cfg_ready  output  1  load word accepted when cfg_valid && cfg_ready
- rd_valid  output  1  readback word valid
- rd_data  output  WORD_W  readback word
- rd_ready  input  1  readback consumer ready
- config_en  output  1  chain shift enable
- config_in  output  1  serial bit into chain
- config_out  input  1  serial bit from chain tail
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse at operation end

Behaviour:
- Reset (reset low, async): state IDLE, all counters cleared. cfg_ready, rd_valid, config_en, config_in, busy and done are 0; rd_data is 0. Reset mid-operation abandons the operation; the chain contents are undefined to the host.
- FSM states: IDLE, LOAD, READ, FIN.
  - IDLE: start=1 goes to LOAD (mode 0) or READ (mode 1) at the next edge.
  - start is ignored in every state except IDLE.
- LOAD, word fetch:
  - A one-word serializer buffer (data + bits-left count) holds the current word.
  - cfg_ready = LOAD && (buffer empty || buffer shifting its last bit this cycle) && words_accepted < NWORDS. No bubble between words when cfg_valid is continuous.
- LOAD, shifting:
  - config_en = buffer non-empty; config_in = buffer bit 0 (LSB first). Both are combinational from registers.
  - A word accepted at edge t produces its first bit with config_en=1 in cycle t+1.
  - Gaps in cfg_valid give config_en=0 cycles; no bit is lost or duplicated.
  - Last word: only its low CHAIN_LEN - (NWORDS-1)*WORD_W bits are shifted; the buffer is discarded after them. Upper bits are ignored.
  - After exactly CHAIN_LEN shift cycles, go to FIN.
- Bit placement: the first bit shifted ends at the chain tail. config_out therefore presents load bit 0 first on a subsequent readback.
- READ, shifting:
  - config_in = config_out (rotation). config_en = 1 in a cycle only if (!rd_valid || rd_ready) and fewer than CHAIN_LEN bits have been read.
  - In each enabled cycle, config_out is captured into packing bit position k (k = 0..WORD_W-1).
- READ, word output:
  - When WORD_W bits (or the final remainder) are packed, the word is registered into rd_data and rd_valid=1 at the next edge. Unused high bits of the last word are 0.
  - rd_data is held stable while rd_valid && !rd_ready.
  - Shifting may continue in the same cycle rd_valid && rd_ready handshake.
  - After CHAIN_LEN enabled cycles the chain is restored to its original contents. Go to FIN once the last word has handshaked.
- FIN: done=1 for one cycle, then IDLE.
- busy = (state != IDLE).
- Counters: bit counter width $clog2(CHAIN_LEN+1); word counter width $clog2(NWORDS+1). Neither wraps: both saturate at the terminal count and clear on entering LOAD or READ.

Decomposition:
- Package config_chain_pkg:
  - state enum {IDLE, LOAD, READ, FIN}
  - MODE_LOAD / MODE_READ constants
  - helper function ceil_div for NWORDS
- No sub-module needed. Serializer, packer and FSM stay in one module (about 200 lines).

Test Plan:
Bench: CHAIN_LEN=40, WORD_W=16 (NWORDS=3), with a 40-bit shift-register chain model driving config_out from its tail.
1. Load 0xA5C3, 0x1234, 0x00FF with continuous cfg_valid -> 40 contiguous config_en cycles. The first config_in is 1 (bit 0 of 0xA5C3), one cycle after the handshake. done pulses once, 41 or more cycles after start.
2. Readback after test 1 with rd_ready=1 -> rd_data sequence 0xA5C3, 0x1234, 0x00FF. The chain model equals its post-load value after the operation.
3. Load with cfg_valid low for 5 cycles between words -> config_en=0 for those gap cycles, total config_en count exactly 40. Readback still matches.
4. Readback with rd_ready held low 7 cycles on the first word -> rd_data stays 0xA5C3 and config_en=0 during the stall. The final word sequence is unchanged.
5. Last load word 0xABFF -> readback returns 0x00FF as the third word.
6. start asserted during LOAD is ignored (no restart). Asserting reset low mid-LOAD -> all outputs 0 immediately and busy=0. A fresh load then completes normally.
